// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light monitor.
// Contents:
//   phase_t     - decoded controller phase as seen on the phase output
//   err_t       - violation codes reported on err_code
//   pat_t       - lamp pattern decoded from the registered lamp drives
//   lamps_t     - registered lamp triple {red, yellow, green}
//   CYCLE_W     - width of the completed-cycle counter
//   decode_lamps, own_pattern, successor - phase/pattern helpers
package traffic_light_pkg;

  localparam int CYCLE_W = 16;

  typedef enum logic [2:0] {
    PH_UNSYNC  = 3'd0,
    PH_RED     = 3'd1,
    PH_RED_YEL = 3'd2,
    PH_GREEN   = 3'd3,
    PH_GRN_YEL = 3'd4
  } phase_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_PATTERN = 3'd1,
    ERR_SEQ     = 3'd2,
    ERR_SHORT   = 3'd3,
    ERR_LONG    = 3'd4
  } err_t;

  typedef enum logic [1:0] {
    PAT_R,
    PAT_Y,
    PAT_G,
    PAT_ILL
  } pat_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamps_t;

  // Exactly one lamp lit is a legal pattern; dark or multiple lamps is not.
  function automatic pat_t decode_lamps(lamps_t l);
    case ({l.red, l.yellow, l.green})
      3'b100:  return PAT_R;
      3'b010:  return PAT_Y;
      3'b001:  return PAT_G;
      default: return PAT_ILL;
    endcase
  endfunction

  // Pattern that keeps a phase alive. Both yellow phases share PAT_Y.
  function automatic pat_t own_pattern(phase_t p);
    case (p)
      PH_RED:                 return PAT_R;
      PH_RED_YEL, PH_GRN_YEL: return PAT_Y;
      PH_GREEN:               return PAT_G;
      default:                return PAT_ILL;
    endcase
  endfunction

  // Only legal successor of each locked phase.
  function automatic phase_t successor(phase_t p);
    case (p)
      PH_RED:     return PH_RED_YEL;
      PH_RED_YEL: return PH_GREEN;
      PH_GREEN:   return PH_GRN_YEL;
      PH_GRN_YEL: return PH_RED;
      default:    return PH_UNSYNC;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Monitor bus: observed lamp drives and error clear toward the monitor,
// decoded phase, error reporting and statistics back from it.
//   master - the side observing the controller (drives lamps, clr_err)
//   slave  - the monitor itself
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  import traffic_light_pkg::*;

  logic               red;
  logic               yellow;
  logic               green;
  logic               clr_err;
  logic [2:0]         phase;
  logic               locked;
  logic               err_pulse;
  logic [2:0]         err_code;
  logic               err_sticky;
  logic [CYCLE_W-1:0] cycle_count;
  logic [CNT_W-1:0]   last_dwell;

  modport master (
    output red, yellow, green, clr_err,
    input  phase, locked, err_pulse, err_code, err_sticky, cycle_count, last_dwell
  );

  modport slave (
    input  red, yellow, green, clr_err,
    output phase, locked, err_pulse, err_code, err_sticky, cycle_count, last_dwell
  );

endinterface

// File: rtl/light_dwell_timer.sv
// Dwell counter for the current phase visit plus bound compares.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         force dwell to 0 (no phase held)
//   start         first cycle of a new visit, dwell becomes 1
//   min_b, max_b  bounds of the phase currently held
//   dwell         cycles spent in the current visit, saturating
//   short         dwell is below min_b (meaningful on exit)
//   long_hit      dwell equals max_b, so one more hold cycle exceeds it
module light_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] min_b,
  input  logic [CNT_W-1:0] max_b,
  output logic [CNT_W-1:0] dwell,
  output logic             short,
  output logic             long_hit
);

  localparam logic [CNT_W-1:0] SAT = '1;

  always_ff @(posedge clk) begin
    if (rst || clear)     dwell <= '0;
    else if (start)       dwell <= CNT_W'(1);
    else if (dwell != SAT) dwell <= dwell + CNT_W'(1);
  end

  assign short    = dwell < min_b;
  // A max equal to the saturation value can never be exceeded; without the
  // guard a saturated counter would keep reporting.
  assign long_hit = (dwell == max_b) && (dwell != SAT);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for a traffic light controller. Lamp drives are
// registered once, decoded to a pattern, and tracked through the
// RED -> RED_YEL -> GREEN -> GRN_YEL -> RED loop with dwell bounds.
// All status outputs are registered, so they move two cycles after a lamp
// change at the inputs.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   mon        slave side of the monitor bus (lamps/clr_err in, status out)
module traffic_light_monitor import traffic_light_pkg::*; #(
  parameter int RED_MIN = 4,
  parameter int RED_MAX = 12,
  parameter int YEL_MIN = 2,
  parameter int YEL_MAX = 4,
  parameter int GRN_MIN = 4,
  parameter int GRN_MAX = 8,
  parameter int CNT_W   = 8
) (
  input logic                     clk,
  input logic                     rst,
  traffic_light_monitor_if.slave  mon
);

  lamps_t             lamps_q;
  pat_t               pat;
  phase_t             phase_q, phase_nxt;
  err_t               err_nxt, err_code_q;
  logic               err_pulse_q, err_sticky_q;
  logic               exit_phase, clear, start, cycle_inc;
  logic [CNT_W-1:0]   min_b, max_b, dwell, last_dwell_q;
  logic               short, long_hit;
  logic [CYCLE_W-1:0] cycle_q;

  // Input stage
  always_ff @(posedge clk) begin
    if (rst) lamps_q <= '0;
    else     lamps_q <= {mon.red, mon.yellow, mon.green};
  end

  assign pat = decode_lamps(lamps_q);

  // Bounds of the phase currently held; UNSYNC gets bounds that never fire.
  always_comb begin
    min_b = '0;
    max_b = '1;
    case (phase_q)
      PH_RED: begin
        min_b = CNT_W'(RED_MIN);
        max_b = CNT_W'(RED_MAX);
      end
      PH_RED_YEL, PH_GRN_YEL: begin
        min_b = CNT_W'(YEL_MIN);
        max_b = CNT_W'(YEL_MAX);
      end
      PH_GREEN: begin
        min_b = CNT_W'(GRN_MIN);
        max_b = CNT_W'(GRN_MAX);
      end
      default: ;
    endcase
  end

  light_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .start    (start),
    .min_b    (min_b),
    .max_b    (max_b),
    .dwell    (dwell),
    .short    (short),
    .long_hit (long_hit)
  );

  // Phase tracking. The if/else order gives the reporting priority
  // PATTERN > SEQ > SHORT; LONG only arises on a held pattern so it never
  // competes with the others.
  always_comb begin
    phase_nxt  = phase_q;
    err_nxt    = ERR_NONE;
    exit_phase = 1'b0;
    clear      = 1'b0;
    start      = 1'b0;
    cycle_inc  = 1'b0;
    if (phase_q == PH_UNSYNC) begin
      // Only solid red resyncs; anything else is silently waited out.
      if (pat == PAT_R) begin
        phase_nxt = PH_RED;
        start     = 1'b1;
      end else begin
        clear = 1'b1;
      end
    end else if (pat == PAT_ILL) begin
      err_nxt    = ERR_PATTERN;
      phase_nxt  = PH_UNSYNC;
      clear      = 1'b1;
      exit_phase = 1'b1;
    end else if (pat == own_pattern(phase_q)) begin
      if (long_hit) err_nxt = ERR_LONG;
    end else if (pat == own_pattern(successor(phase_q))) begin
      phase_nxt  = successor(phase_q);
      start      = 1'b1;
      exit_phase = 1'b1;
      cycle_inc  = (phase_q == PH_GRN_YEL);
      if (short) err_nxt = ERR_SHORT;
    end else begin
      err_nxt    = ERR_SEQ;
      phase_nxt  = PH_UNSYNC;
      clear      = 1'b1;
      exit_phase = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_UNSYNC;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_sticky_q <= 1'b0;
      cycle_q      <= '0;
      last_dwell_q <= '0;
    end else begin
      phase_q     <= phase_nxt;
      err_pulse_q <= (err_nxt != ERR_NONE);
      if (err_nxt != ERR_NONE) err_code_q <= err_nxt;
      // A clear arriving with a new violation, or while the strobe for one
      // is still up, must not hide it.
      if (err_nxt != ERR_NONE)               err_sticky_q <= 1'b1;
      else if (mon.clr_err && !err_pulse_q)  err_sticky_q <= 1'b0;
      if (cycle_inc)  cycle_q      <= cycle_q + CYCLE_W'(1);
      if (exit_phase) last_dwell_q <= dwell;
    end
  end

  assign mon.phase       = phase_q;
  assign mon.locked      = (phase_q != PH_UNSYNC);
  assign mon.err_pulse   = err_pulse_q;
  assign mon.err_code    = err_code_q;
  assign mon.err_sticky  = err_sticky_q;
  assign mon.cycle_count = cycle_q;
  assign mon.last_dwell  = last_dwell_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;
  import traffic_light_pkg::*;

  localparam logic [2:0] L_R  = 3'b100;
  localparam logic [2:0] L_Y  = 3'b010;
  localparam logic [2:0] L_G  = 3'b001;
  localparam logic [2:0] L_RG = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_light_monitor_if #(.CNT_W(8)) bus ();

  traffic_light_monitor #(
    .RED_MIN(4), .RED_MAX(12), .YEL_MIN(2), .YEL_MAX(4),
    .GRN_MIN(4), .GRN_MAX(8), .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  typedef struct {
    logic [2:0] lamps;
    logic       clr;
    logic [2:0] ph;
    logic       pulse;
    logic [2:0] code;
  } step_t;

  step_t      stim[$];
  step_t      sb[$];
  int         total = 0;
  int         bad = 0;
  logic [2:0] cur_code = 3'd0;

  // Append n cycles of one lamp pattern with the phase it must produce;
  // err_at marks the cycle (within this run) that must strobe 'code'.
  task automatic add_seg(input logic [2:0] l, input int n, input logic [2:0] ph,
                         input int err_at = -1, input logic [2:0] code = 3'd0,
                         input logic clr = 1'b0);
    for (int i = 0; i < n; i++) begin
      step_t s;
      s.lamps = l;
      s.clr   = clr;
      s.ph    = ph;
      s.pulse = (i == err_at);
      if (i == err_at) cur_code = code;
      s.code  = cur_code;
      stim.push_back(s);
    end
  endtask

  task automatic drive(input step_t s);
    bus.red     = s.lamps[2];
    bus.yellow  = s.lamps[1];
    bus.green   = s.lamps[0];
    bus.clr_err = s.clr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.red = 1'b0; bus.yellow = 1'b0; bus.green = 1'b0; bus.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    stim.delete();
    cur_code = 3'd0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.phase, bus.locked, bus.err_pulse, bus.err_code, bus.err_sticky} !== 9'd0) begin
      bad++;
      $display("FAIL reset_status: phase/locked/pulse/code/sticky=%0d/%b/%b/%0d/%b required all 0",
               bus.phase, bus.locked, bus.err_pulse, bus.err_code, bus.err_sticky);
    end
    total++;
    if ({bus.cycle_count, bus.last_dwell} !== 24'd0) begin
      bad++;
      $display("FAIL reset_counts: cycle_count=%0d last_dwell=%0d required 0/0", bus.cycle_count, bus.last_dwell);
    end
  endtask

  task automatic test_legal_loop();
    int n;
    do_reset();
    add_seg(L_R, 6, PH_RED);
    add_seg(L_Y, 3, PH_RED_YEL);
    add_seg(L_G, 5, PH_GREEN);
    add_seg(L_Y, 3, PH_GRN_YEL);
    add_seg(L_R, 1, PH_RED);
    n = stim.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (sb.size() >= 2 || (i >= n && sb.size() > 0)) begin
        step_t e;
        e = sb.pop_front();
        total++;
        if ({bus.phase, bus.err_pulse, bus.err_code} !== {e.ph, e.pulse, e.code}) begin
          bad++;
          $display("FAIL legal_loop step: phase/pulse/code=%0d/%b/%0d required %0d/%b/%0d",
                   bus.phase, bus.err_pulse, bus.err_code, e.ph, e.pulse, e.code);
        end
      end
      if (i < n) begin drive(stim[i]); sb.push_back(stim[i]); end
    end
    total++;
    if ({bus.cycle_count, bus.last_dwell, bus.err_sticky, bus.locked} !== {16'd1, 8'd3, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL legal_loop end: cycle_count=%0d last_dwell=%0d sticky=%b locked=%b required 1/3/0/1",
               bus.cycle_count, bus.last_dwell, bus.err_sticky, bus.locked);
    end
  endtask

  task automatic test_pattern();
    int n;
    do_reset();
    add_seg(L_R, 6, PH_RED);
    add_seg(L_RG, 2, PH_UNSYNC, 0, ERR_PATTERN);
    n = stim.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (sb.size() >= 2 || (i >= n && sb.size() > 0)) begin
        step_t e;
        e = sb.pop_front();
        total++;
        if ({bus.phase, bus.err_pulse, bus.err_code} !== {e.ph, e.pulse, e.code}) begin
          bad++;
          $display("FAIL pattern step: phase/pulse/code=%0d/%b/%0d required %0d/%b/%0d",
                   bus.phase, bus.err_pulse, bus.err_code, e.ph, e.pulse, e.code);
        end
      end
      if (i < n) begin drive(stim[i]); sb.push_back(stim[i]); end
    end
    total++;
    if ({bus.err_sticky, bus.locked} !== 2'b10) begin
      bad++;
      $display("FAIL pattern end: sticky=%b locked=%b required 1/0", bus.err_sticky, bus.locked);
    end
  endtask

  task automatic test_seq();
    int n;
    do_reset();
    add_seg(L_R, 6, PH_RED);
    add_seg(L_G, 1, PH_UNSYNC, 0, ERR_SEQ);
    add_seg(L_R, 3, PH_RED);
    n = stim.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (sb.size() >= 2 || (i >= n && sb.size() > 0)) begin
        step_t e;
        e = sb.pop_front();
        total++;
        if ({bus.phase, bus.err_pulse, bus.err_code} !== {e.ph, e.pulse, e.code}) begin
          bad++;
          $display("FAIL seq step: phase/pulse/code=%0d/%b/%0d required %0d/%b/%0d",
                   bus.phase, bus.err_pulse, bus.err_code, e.ph, e.pulse, e.code);
        end
      end
      if (i < n) begin drive(stim[i]); sb.push_back(stim[i]); end
    end
    total++;
    if ({bus.err_sticky, bus.locked} !== 2'b11) begin
      bad++;
      $display("FAIL seq end: sticky=%b locked=%b required 1/1", bus.err_sticky, bus.locked);
    end
  endtask

  task automatic test_short();
    int n;
    do_reset();
    add_seg(L_R, 2, PH_RED);
    add_seg(L_Y, 1, PH_RED_YEL, 0, ERR_SHORT);
    n = stim.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (sb.size() >= 2 || (i >= n && sb.size() > 0)) begin
        step_t e;
        e = sb.pop_front();
        total++;
        if ({bus.phase, bus.err_pulse, bus.err_code} !== {e.ph, e.pulse, e.code}) begin
          bad++;
          $display("FAIL short step: phase/pulse/code=%0d/%b/%0d required %0d/%b/%0d",
                   bus.phase, bus.err_pulse, bus.err_code, e.ph, e.pulse, e.code);
        end
      end
      if (i < n) begin drive(stim[i]); sb.push_back(stim[i]); end
    end
    total++;
    if (bus.last_dwell !== 8'd2) begin
      bad++;
      $display("FAIL short last_dwell: got %0d required 2", bus.last_dwell);
    end
  endtask

  task automatic test_long();
    int n;
    do_reset();
    add_seg(L_R, 4, PH_RED);
    add_seg(L_Y, 2, PH_RED_YEL);
    add_seg(L_G, 20, PH_GREEN, 8, ERR_LONG);
    n = stim.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (sb.size() >= 2 || (i >= n && sb.size() > 0)) begin
        step_t e;
        e = sb.pop_front();
        total++;
        if ({bus.phase, bus.err_pulse, bus.err_code} !== {e.ph, e.pulse, e.code}) begin
          bad++;
          $display("FAIL long step: phase/pulse/code=%0d/%b/%0d required %0d/%b/%0d",
                   bus.phase, bus.err_pulse, bus.err_code, e.ph, e.pulse, e.code);
        end
      end
      if (i < n) begin drive(stim[i]); sb.push_back(stim[i]); end
    end
    total++;
    if ({bus.err_sticky, bus.last_dwell} !== {1'b1, 8'd2}) begin
      bad++;
      $display("FAIL long end: sticky=%b last_dwell=%0d required 1/2", bus.err_sticky, bus.last_dwell);
    end
  endtask

  task automatic test_rst_clr();
    int n;
    do_reset();
    add_seg(L_R, 4, PH_RED);
    add_seg(L_Y, 2, PH_RED_YEL);
    add_seg(L_G, 3, PH_GREEN);
    n = stim.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (sb.size() >= 2 || (i >= n && sb.size() > 0)) begin
        step_t e;
        e = sb.pop_front();
        total++;
        if ({bus.phase, bus.err_pulse, bus.err_code} !== {e.ph, e.pulse, e.code}) begin
          bad++;
          $display("FAIL rst_green step: phase/pulse/code=%0d/%b/%0d required %0d/%b/%0d",
                   bus.phase, bus.err_pulse, bus.err_code, e.ph, e.pulse, e.code);
        end
      end
      if (i < n) begin drive(stim[i]); sb.push_back(stim[i]); end
    end
    // Reset in the middle of GREEN with the green lamp still lit.
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.phase, bus.locked, bus.err_pulse, bus.err_code, bus.err_sticky,
         bus.cycle_count, bus.last_dwell} !== 33'd0) begin
      bad++;
      $display("FAIL rst_mid outputs: phase=%0d locked=%b pulse=%b code=%0d sticky=%b cycles=%0d last_dwell=%0d required all 0",
               bus.phase, bus.locked, bus.err_pulse, bus.err_code, bus.err_sticky, bus.cycle_count, bus.last_dwell);
    end
    rst = 1'b0;
    sb.delete();
    stim.delete();
    cur_code = 3'd0;
    add_seg(L_R, 2, PH_RED);
    add_seg(L_G, 1, PH_UNSYNC, 0, ERR_SEQ, 1'b1);
    add_seg(L_G, 2, PH_UNSYNC, -1, 3'd0, 1'b1);
    add_seg(L_G, 2, PH_UNSYNC);
    n = stim.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (sb.size() >= 2 || (i >= n && sb.size() > 0)) begin
        step_t e;
        e = sb.pop_front();
        total++;
        if ({bus.phase, bus.err_pulse, bus.err_code} !== {e.ph, e.pulse, e.code}) begin
          bad++;
          $display("FAIL clr_seq step: phase/pulse/code=%0d/%b/%0d required %0d/%b/%0d",
                   bus.phase, bus.err_pulse, bus.err_code, e.ph, e.pulse, e.code);
        end
      end
      if (i < n) begin drive(stim[i]); sb.push_back(stim[i]); end
    end
    total++;
    if (bus.err_sticky !== 1'b1) begin
      bad++;
      $display("FAIL clr_coincident sticky: got %b required 1", bus.err_sticky);
    end
    // A clear with no violation in flight does drop the sticky flag.
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    total++;
    if (bus.err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL clr_alone sticky: got %b required 0", bus.err_sticky);
    end
  endtask

  initial begin
    bus.red = 1'b0; bus.yellow = 1'b0; bus.green = 1'b0; bus.clr_err = 1'b0;
    test_reset();
    test_legal_loop();
    test_pattern();
    test_seq();
    test_short();
    test_long();
    test_rst_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL provide parameter RED_MIN, default 4, minimum legal RED dwell in cycles.
REQ-002 SHALL provide parameter RED_MAX, default 12, maximum legal RED dwell in cycles.
REQ-003 SHALL provide parameter YEL_MIN, default 2, and YEL_MAX, default 4, bounds shared by both yellow phases.
REQ-004 SHALL provide parameter GRN_MIN, default 4, and GRN_MAX, default 8, GREEN dwell bounds.
REQ-005 SHALL provide parameter CNT_W, default 8, dwell counter width.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 red, yellow, green  input  1 each  observed lamp drives from a traffic light controller.
REQ-009 clr_err  input  1  clears err_sticky.
REQ-010 phase  output  3  decoded phase: 0 UNSYNC, 1 RED, 2 RED_YEL, 3 GREEN, 4 GRN_YEL.
REQ-011 locked  output  1  high when phase != UNSYNC.
REQ-012 err_pulse  output  1  one-cycle strobe per detected violation.
REQ-013 err_code  output  3  code of last violation: 0 none, 1 PATTERN, 2 SEQ, 3 SHORT, 4 LONG; holds until next violation.
REQ-014 err_sticky  output  1  set by any err_pulse, cleared by clr_err.
REQ-015 cycle_count  output  16  completed RED->RED_YEL->GREEN->GRN_YEL->RED cycles, wraps modulo 2^16.
REQ-016 last_dwell  output  CNT_W  dwell of the most recently exited phase.

Function
REQ-017 Lamp inputs SHALL be registered once; patterns are decoded from registered lamps: R only = R, Y only = Y, G only = G, anything else = ILLEGAL.
REQ-018 phase, err_pulse, err_code, last_dwell, cycle_count SHALL update exactly 2 cycles after the lamp change at the inputs.
REQ-019 In UNSYNC, the R pattern SHALL enter RED with dwell=1; all other patterns SHALL be ignored without error.
REQ-020 Legal transitions on pattern change: RED+Y->RED_YEL, RED_YEL+G->GREEN, GREEN+Y->GRN_YEL, GRN_YEL+R->RED; entry sets dwell=1.
REQ-021 GRN_YEL->RED SHALL increment cycle_count in the same cycle phase becomes RED.
REQ-022 Unchanged pattern SHALL increment dwell, saturating at 2^CNT_W-1.
REQ-023 On leaving a phase, last_dwell SHALL take the exiting dwell value.
REQ-024 ILLEGAL pattern while locked SHALL pulse PATTERN and go to UNSYNC.
REQ-025 Legal pattern that is not the legal successor while locked SHALL pulse SEQ and go to UNSYNC.
REQ-026 Legal transition with exiting dwell < phase MIN SHALL pulse SHORT; transition is still taken.
REQ-027 Dwell reaching phase MAX+1 SHALL pulse LONG once per phase visit; phase retained.
REQ-028 Simultaneous violations SHALL report one pulse, priority PATTERN > SEQ > SHORT.
REQ-029 clr_err coincident with err_pulse SHALL leave err_sticky set.

Reset
REQ-030 On rst: input register=000, phase=UNSYNC, locked=0, err_pulse=0, err_code=0, err_sticky=0, cycle_count=0, last_dwell=0, dwell=0.
REQ-031 rst asserted mid-phase SHALL discard the visit without any error or last_dwell update; resync per REQ-019 after release.

Structure
REQ-032 Phase encodings and error codes SHALL reside in shared package traffic_light_pkg.
REQ-033 Dwell counting, saturation and MIN/MAX compare SHALL be a sub-module light_dwell_timer (inputs: clear, phase bounds; outputs: dwell, short, long_hit).

Verification
REQ-034 Legal loop R×6, Y×3, G×5, Y×3, R -> no err_pulse, phase 1,2,3,4,1, cycle_count=1, last_dwell=3 after final entry.
REQ-035 R×6 then R+G both high -> err_pulse, err_code=1, phase=0, err_sticky=1.
REQ-036 R×6 then G -> err_code=2, phase=0; subsequent R -> phase=1 with no further error.
REQ-037 R×2 then Y -> err_code=3, phase=2, last_dwell=2.
REQ-038 G held 20 cycles after legal entry -> exactly one err_pulse code 4 when dwell=9, phase stays 3.
REQ-039 rst during GREEN, then clr_err with simultaneous SEQ error -> all outputs at reset values, then err_sticky remains 1.
